// File: rtl/param_bus_datapath.sv
// Single-bus processor datapath: GPR file, PC/IR/MDR/Y/HI/LO, 2*WIDTH Z register,
// single-cycle ALU and a multi-cycle signed Booth multiplier / restoring divider.
module param_bus_datapath #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 16,
   parameter bit R0_ZERO  = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REGS+7:0]   out_sel,
   input  logic [NUM_REGS-1:0]   reg_in,
   input  logic                  pc_in,
   input  logic                  ir_in,
   input  logic                  y_in,
   input  logic                  hi_in,
   input  logic                  lo_in,
   input  logic                  mdr_in,
   input  logic                  mdr_read,
   input  logic [WIDTH-1:0]      mdata_in,
   input  logic [WIDTH-1:0]      in_port,
   input  logic [WIDTH-1:0]      const_in,
   input  logic [3:0]            alu_op,
   input  logic                  z_in,
   input  logic                  alu_start,
   output logic                  alu_busy,
   output logic                  alu_done,
   output logic                  div0,
   output logic                  sel_err,
   output logic [WIDTH-1:0]      bus_out,
   output logic [WIDTH-1:0]      ir_val,
   output logic [WIDTH-1:0]      mdr_val,
   output logic [WIDTH-1:0]      hi_val,
   output logic [WIDTH-1:0]      lo_val,
   output logic [WIDTH-1:0]      pc_val,
   output logic [WIDTH-1:0]      zhigh,
   output logic [WIDTH-1:0]      zlow
);

   localparam int SH = $clog2(WIDTH);
   localparam int SEL_HI  = NUM_REGS;
   localparam int SEL_LO  = NUM_REGS + 1;
   localparam int SEL_ZHI = NUM_REGS + 2;
   localparam int SEL_ZLO = NUM_REGS + 3;
   localparam int SEL_PC  = NUM_REGS + 4;
   localparam int SEL_MDR = NUM_REGS + 5;
   localparam int SEL_IN  = NUM_REGS + 6;
   localparam int SEL_CON = NUM_REGS + 7;
   localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] gpr_q [NUM_REGS];
   logic [WIDTH-1:0] gpr_d [NUM_REGS];
   logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, y_q, y_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, z_hi_q, z_hi_d, z_lo_q, z_lo_d;
   logic             div0_q, div0_d;
   logic [SH-1:0]    cnt_q, cnt_d;
   logic             op_div_q, op_div_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d, dvs_q, dvs_d, dvd_q, dvd_d;
   logic             qm1_q, qm1_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;

   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] alu_res;
   logic [SH-1:0]    sh;
   logic [2*WIDTH-1:0] dbl, rot_r, rot_l;
   logic             start_ok;

   logic [WIDTH:0]   mul_sum, mul_acc_n, div_shift, div_trial;
   logic [WIDTH-1:0] mul_q_n, div_rem_n, div_q_n, quot_s, rem_s;
   logic             mul_qm1_n;

   // Bus: OR of every selected source, so overlapping selects are visible as sel_err
   always_comb begin
      bus = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (out_sel[i] && !(R0_ZERO && i == 0)) bus = bus | gpr_q[i];
      end
      if (out_sel[SEL_HI])  bus = bus | hi_q;
      if (out_sel[SEL_LO])  bus = bus | lo_q;
      if (out_sel[SEL_ZHI]) bus = bus | z_hi_q;
      if (out_sel[SEL_ZLO]) bus = bus | z_lo_q;
      if (out_sel[SEL_PC])  bus = bus | pc_q;
      if (out_sel[SEL_MDR]) bus = bus | mdr_q;
      if (out_sel[SEL_IN])  bus = bus | in_port;
      if (out_sel[SEL_CON]) bus = bus | const_in;
   end

   assign sel_err = (out_sel & (out_sel - 1'b1)) != '0;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         gpr_d[i] = gpr_q[i];
         if (reg_in[i] && !(R0_ZERO && i == 0)) gpr_d[i] = bus;
      end
      pc_d  = pc_in ? bus : pc_q;
      ir_d  = ir_in ? bus : ir_q;
      y_d   = y_in  ? bus : y_q;
      hi_d  = hi_in ? bus : hi_q;
      lo_d  = lo_in ? bus : lo_q;
      mdr_d = mdr_q;
      if (mdr_in) mdr_d = mdr_read ? mdata_in : bus;
   end

   // Single-cycle ALU: A = Y, B = bus
   always_comb begin
      sh    = bus[SH-1:0];
      dbl   = {y_q, y_q};
      rot_r = dbl >> sh;
      rot_l = dbl << sh;
      case (alu_op)
         4'd0:    alu_res = y_q + bus;
         4'd1:    alu_res = y_q - bus;
         4'd2:    alu_res = y_q & bus;
         4'd3:    alu_res = y_q | bus;
         4'd4:    alu_res = y_q >> sh;
         4'd5:    alu_res = $signed(y_q) >>> sh;
         4'd6:    alu_res = y_q << sh;
         4'd7:    alu_res = rot_r[WIDTH-1:0];
         4'd8:    alu_res = rot_l[2*WIDTH-1:WIDTH];
         4'd9:    alu_res = -bus;
         4'd10:   alu_res = ~bus;
         4'd11:   alu_res = bus + 1'b1;
         default: alu_res = '0;
      endcase
   end

   // One iteration of Booth multiply and of restoring divide on magnitudes
   always_comb begin
      case ({q_q[0], qm1_q})
         2'b01:   mul_sum = acc_q + {dvs_q[WIDTH-1], dvs_q};
         2'b10:   mul_sum = acc_q - {dvs_q[WIDTH-1], dvs_q};
         default: mul_sum = acc_q;
      endcase
      mul_acc_n = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
      mul_q_n   = {mul_sum[0], q_q[WIDTH-1:1]};
      mul_qm1_n = q_q[0];

      div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, dvs_q};
      if (!div_trial[WIDTH]) begin
         div_rem_n = div_trial[WIDTH-1:0];
         div_q_n   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         div_rem_n = div_shift[WIDTH-1:0];
         div_q_n   = {q_q[WIDTH-2:0], 1'b0};
      end
      quot_s = neg_q_q ? -div_q_n : div_q_n;
      rem_s  = neg_r_q ? -div_rem_n : div_rem_n;
   end

   assign start_ok = alu_start && (alu_op == 4'd12 || alu_op == 4'd13);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_div_d = op_div_q;
      acc_d    = acc_q;
      q_d      = q_q;
      qm1_d    = qm1_q;
      dvs_d    = dvs_q;
      dvd_d    = dvd_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      dz_d     = dz_q;
      z_hi_d   = z_hi_q;
      z_lo_d   = z_lo_q;
      div0_d   = div0_q;
      case (state_q)
         RUN: begin
            cnt_d = cnt_q + SH'(1);
            if (op_div_q) begin
               acc_d = {1'b0, div_rem_n};
               q_d   = div_q_n;
            end else begin
               acc_d = mul_acc_n;
               q_d   = mul_q_n;
               qm1_d = mul_qm1_n;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               if (!op_div_q) begin
                  z_hi_d = mul_acc_n[WIDTH-1:0];
                  z_lo_d = mul_q_n;
               end else if (dz_q) begin
                  z_hi_d = dvd_q;
                  z_lo_d = '1;
                  div0_d = 1'b1;
               end else begin
                  z_hi_d = rem_s;
                  z_lo_d = quot_s;
               end
            end
         end
         default: begin
            state_d = IDLE;
            if (z_in && alu_op < 4'd12) begin
               z_hi_d = '0;
               z_lo_d = alu_res;
            end
            if (start_ok) begin
               state_d  = RUN;
               cnt_d    = '0;
               op_div_d = alu_op[0];
               acc_d    = '0;
               qm1_d    = 1'b0;
               dvd_d    = y_q;
               neg_q_d  = y_q[WIDTH-1] ^ bus[WIDTH-1];
               neg_r_d  = y_q[WIDTH-1];
               dz_d     = (bus == '0);
               div0_d   = 1'b0;
               if (alu_op[0]) begin
                  q_d   = y_q[WIDTH-1] ? -y_q : y_q;
                  dvs_d = bus[WIDTH-1] ? -bus : bus;
               end else begin
                  q_d   = bus;
                  dvs_d = y_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
         state_q  <= IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         mdr_q    <= '0;
         y_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         z_hi_q   <= '0;
         z_lo_q   <= '0;
         div0_q   <= 1'b0;
         cnt_q    <= '0;
         op_div_q <= 1'b0;
         acc_q    <= '0;
         q_q      <= '0;
         qm1_q    <= 1'b0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         gpr_q    <= gpr_d;
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         mdr_q    <= mdr_d;
         y_q      <= y_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         z_hi_q   <= z_hi_d;
         z_lo_q   <= z_lo_d;
         div0_q   <= div0_d;
         cnt_q    <= cnt_d;
         op_div_q <= op_div_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         qm1_q    <= qm1_d;
         dvs_q    <= dvs_d;
         dvd_q    <= dvd_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
      end
   end

   assign alu_busy = (state_q == RUN);
   assign alu_done = (state_q == DONE);
   assign div0     = div0_q;
   assign bus_out  = bus;
   assign ir_val   = ir_q;
   assign mdr_val  = mdr_q;
   assign hi_val   = hi_q;
   assign lo_val   = lo_q;
   assign pc_val   = pc_q;
   assign zhigh    = z_hi_q;
   assign zlow     = z_lo_q;

endmodule
